radix2_bf_pipe: RTL
===================

# radix2_bf_pipe

Parametrised, pipelined radix-2 decimation-in-frequency butterfly for the streaming FFT datapath. Each butterfly stage holds its upper-leg sample A for DELAY cycles, then emits A+B and A−B. Each result is either scaled by 1/2 with rounding or kept at full scale with saturation, selectable per sample. The block adds valid tracking, clock-enable stalls, a sticky overflow flag and a configurable alignment depth, so one module serves every stage of an N-point pipeline.

## Interface
- DW, 16: sample width per real/imag component, signed two's complement, 4..32.
- DELAY, 10: number of alignment registers on the A path, 0..1024.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0, every pipeline register holds.
- in_valid  in  1  qualifies dinb and scale in the current cycle.
- scale  in  1  1 = result scaled by 1/2 with rounding; 0 = unscaled with saturation.
- dina_r, dina_i  in  DW  upper-leg sample, signed; must be presented DELAY ce-cycles before its partner B.
- dinb_r, dinb_i  in  DW  lower-leg sample, signed.
- ovf_clr  in  1  clears the sticky overflow flag.
- out_valid  out  1  qualifies douta/doutb.
- douta_r, douta_i  out  DW  A+B result, signed.
- doutb_r, doutb_i  out  DW  A−B result, signed.
- ovf  out  1  sticky; set when any unscaled result saturated.

## Operation
- A delay line: DELAY registers per component, advancing only when ce=1. With DELAY=0, dina feeds stage 1 directly. A runs free and is not gated by in_valid.
- Stage 1 (ce=1):
  - sum = A + B and dif = A − B, sign-extended to DW+1 bits.
  - Latches in_valid and scale into the pipeline.
- Stage 2 (ce=1), using the stage-1 scale bit:
  - scale=1: out = (x + 1) >>> 1, computed in DW+2 bits (round half up). The result always fits DW bits, so no saturation.
  - scale=0: out = x clamped to [−2^(DW−1), 2^(DW−1)−1]. Any clamp sets ovf on that cycle.
  - Each of the four components is handled independently.
- ovf behaviour:
  - ovf_clr=1 with no new saturation: ovf cleared next cycle.
  - Saturation in the same cycle as ovf_clr: ovf stays 1 (set wins).
  - ovf_clr acts regardless of ce.
- out_valid is the stage-2 copy of in_valid. Outputs are registered and hold between valid samples.
- Reset (rst=1 on a clock edge, any cycle, including mid-frame):
  - All delay-line registers, pipeline registers and outputs go to 0, and out_valid and ovf go to 0.
  - Data in flight is discarded.
  - rst overrides ce and ovf_clr.

## Timing
- Latency from dinb/in_valid to douta/doutb/out_valid is 2 ce-cycles.
- Latency from dina is DELAY+2 ce-cycles.
- ce=0 freezes everything, including out_valid. Downstream logic samples outputs only when ce=1, so a held out_valid during a stall is never double-counted.
- No backpressure; throughput is one butterfly per ce-cycle.
- Reset values:
  - douta_*, doutb_* = 0.
  - out_valid = 0.
  - ovf = 0.
  - All internal registers = 0.
- The first valid output appears no earlier than 2 ce-cycles after rst deasserts.

## Structure
- Shared package fft_pkg:
  - DW default constant.
  - Function sat_dw(x, DW) performing the clamp.
  - Function rnd_half(x) performing the rounded shift.
  - Both functions are reused by later twiddle and stage blocks.
- Sub-module fft_delay_line (parameters DW, DEPTH; ports clk, rst, ce, din, dout):
  - Instantiated twice, for dina_r and dina_i.
  - DEPTH=0 degenerates to a wire.
- Top-level radix2_bf_pipe holds stage 1, stage 2 and the ovf logic.

## Test plan
- DW=16, DELAY=10, scale=1:
  - Stimulus: A=(1000, −200) at t, then B=(600, 100) with in_valid at t+10.
  - Response: out_valid at t+12 with douta=(800, −50) and doutb=(200, −150).
- scale=1 rounding:
  - Stimulus: A=3, B=0.
  - Response: douta=2, doutb=2. A=−3, B=0 gives −1, −1.
  - Stimulus: A=32767, B=32767.
  - Response: douta=32767, no ovf.
- scale=0 saturation:
  - Stimulus: A=30000, B=10000.
  - Response: douta=32767, doutb=20000, and ovf=1 next cycle.
  - Stimulus: A=−30000, B=10000.
  - Response: doutb=−32768.
  - ovf stays 1 until ovf_clr. Saturation concurrent with ovf_clr keeps ovf=1.
- ce stall:
  - Stimulus: a stream of 20 valid samples with ce low for 3 cycles mid-stream.
  - Response: output sequence identical to the unstalled run, with no dropped or duplicated sample when counted on ce=1 cycles.
- Reset mid-frame:
  - Stimulus: rst=1 for 1 cycle with the delay line full.
  - Response: next cycle all outputs, out_valid and ovf = 0. The subsequent 10 ce-cycles of douta reflect A=0 in the delay line.
- DELAY=0, DW=8:
  - Stimulus: A=B=127, scale=0.
  - Response: douta=127 with ovf=1, doutb=0, latency 2.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: default sample width, saturating clamp, rounded halving.
// Latency: n/a (package of constants and combinational functions).
// Backpressure: n/a.
//
// Reused by the butterfly, twiddle and stage blocks. The functions operate on
// 64-bit signed values so that any width up to 32 bits (plus growth bits) fits.
package fft_pkg;

    localparam int DW_DEF = 16;

    // Clamp x into the signed range of a dw-bit two's complement number.
    function automatic longint sat_dw(input longint x, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -(longint'(1) << (dw - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Divide by two, rounding half up: (x + 1) >>> 1.
    function automatic longint rnd_half(input longint x);
        return (x + 1) >>> 1;
    endfunction

endpackage

// File: rtl/radix2_bf_pipe_if.sv
// Butterfly stream bundle: enable, two input legs, per-sample mode, two result legs, overflow.
// Latency: n/a (wires only).
// Backpressure: none; ce stalls the whole pipeline, there is no ready signal.
//
// Ports (slave = butterfly view):
//   in : ce, in_valid, scale, ovf_clr, dina_r/i, dinb_r/i
//   out: out_valid, ovf, douta_r/i (A+B), doutb_r/i (A-B)
interface radix2_bf_pipe_if
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic                 ce;
    logic                 in_valid;
    logic                 scale;
    logic                 ovf_clr;
    logic signed [DW-1:0] dina_r;
    logic signed [DW-1:0] dina_i;
    logic signed [DW-1:0] dinb_r;
    logic signed [DW-1:0] dinb_i;
    logic                 out_valid;
    logic                 ovf;
    logic signed [DW-1:0] douta_r;
    logic signed [DW-1:0] douta_i;
    logic signed [DW-1:0] doutb_r;
    logic signed [DW-1:0] doutb_i;

    modport master (
        output ce, in_valid, scale, ovf_clr, dina_r, dina_i, dinb_r, dinb_i,
        input  out_valid, ovf, douta_r, douta_i, doutb_r, doutb_i
    );

    modport slave (
        input  ce, in_valid, scale, ovf_clr, dina_r, dina_i, dinb_r, dinb_i,
        output out_valid, ovf, douta_r, douta_i, doutb_r, doutb_i
    );
endinterface

// File: rtl/fft_delay_line.sv
// Alignment shift register of DEPTH words, advancing only on ce; DEPTH=0 is a plain wire.
// Latency: DEPTH ce-cycles.
// Backpressure: none; ce=0 holds every stage.
//
// Ports: clk, rst (sync, active high), ce, din[DW], dout[DW].
module fft_delay_line #(
    parameter int DW    = 16,
    parameter int DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign dout        = din;
        end else begin : g_regs
            logic signed [DW-1:0] dly_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (ce) begin
                    dly_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign dout = dly_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/radix2_bf_pipe.sv
// Radix-2 DIF butterfly: A delayed DELAY ce-cycles, then A+B / A-B, scaled-rounded or saturated.
// Latency: 2 ce-cycles from dinb/in_valid, DELAY+2 from dina.
// Backpressure: none; one butterfly per ce-cycle, ce=0 freezes every register.
//
// Ports: clk, rst (sync, active high), bus (radix2_bf_pipe_if.slave).
module radix2_bf_pipe
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DELAY = 10
) (
    input  logic            clk,
    input  logic            rst,
    radix2_bf_pipe_if.slave bus
);

    // Stage 2 result for one component: halve with rounding, or clamp to DW bits.
    function automatic logic signed [DW-1:0] post(input logic signed [DW:0] x, input logic sc);
        if (sc) begin
            return DW'(rnd_half(longint'(x)));
        end
        return DW'(sat_dw(longint'(x), DW));
    endfunction

    // True when the unscaled path has to clamp this component.
    function automatic logic clamps(input logic signed [DW:0] x, input logic sc);
        return !sc && (sat_dw(longint'(x), DW) != longint'(x));
    endfunction

    logic signed [DW-1:0] a_r_dly;
    logic signed [DW-1:0] a_i_dly;

    fft_delay_line #(.DW(DW), .DEPTH(DELAY)) u_dly_r (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .din  (bus.dina_r),
        .dout (a_r_dly)
    );

    fft_delay_line #(.DW(DW), .DEPTH(DELAY)) u_dly_i (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .din  (bus.dina_i),
        .dout (a_i_dly)
    );

    // Stage 1: one bit of growth, no rounding yet.
    logic signed [DW:0] sum_r_d, sum_i_d, dif_r_d, dif_i_d;
    logic signed [DW:0] sum_r_q, sum_i_q, dif_r_q, dif_i_q;
    logic               vld1_q, scl1_q;

    always_comb begin
        sum_r_d = (DW+1)'(a_r_dly) + (DW+1)'(bus.dinb_r);
        sum_i_d = (DW+1)'(a_i_dly) + (DW+1)'(bus.dinb_i);
        dif_r_d = (DW+1)'(a_r_dly) - (DW+1)'(bus.dinb_r);
        dif_i_d = (DW+1)'(a_i_dly) - (DW+1)'(bus.dinb_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r_q <= '0;
            sum_i_q <= '0;
            dif_r_q <= '0;
            dif_i_q <= '0;
            vld1_q  <= 1'b0;
            scl1_q  <= 1'b0;
        end else if (bus.ce) begin
            sum_r_q <= sum_r_d;
            sum_i_q <= sum_i_d;
            dif_r_q <= dif_r_d;
            dif_i_q <= dif_i_d;
            vld1_q  <= bus.in_valid;
            scl1_q  <= bus.scale;
        end
    end

    // Stage 2: per-component post-processing and the sticky overflow flag.
    logic signed [DW-1:0] douta_r_d, douta_i_d, doutb_r_d, doutb_i_d;
    logic signed [DW-1:0] douta_r_q, douta_i_q, doutb_r_q, doutb_i_q;
    logic                 vld2_q;
    logic                 sat_any;
    logic                 ovf_d, ovf_q;

    always_comb begin
        douta_r_d = post(sum_r_q, scl1_q);
        douta_i_d = post(sum_i_q, scl1_q);
        doutb_r_d = post(dif_r_q, scl1_q);
        doutb_i_d = post(dif_i_q, scl1_q);
        sat_any   = clamps(sum_r_q, scl1_q) | clamps(sum_i_q, scl1_q)
                  | clamps(dif_r_q, scl1_q) | clamps(dif_i_q, scl1_q);
        // A new saturation beats a simultaneous clear; the clear ignores ce.
        ovf_d     = (bus.ce & vld1_q & sat_any) | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            douta_r_q <= '0;
            douta_i_q <= '0;
            doutb_r_q <= '0;
            doutb_i_q <= '0;
            vld2_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (bus.ce) begin
                vld2_q <= vld1_q;
                // Result registers hold their last valid sample across bubbles.
                if (vld1_q) begin
                    douta_r_q <= douta_r_d;
                    douta_i_q <= douta_i_d;
                    doutb_r_q <= doutb_r_d;
                    doutb_i_q <= doutb_i_d;
                end
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = vld2_q;
    assign bus.ovf       = ovf_q;
    assign bus.douta_r   = douta_r_q;
    assign bus.douta_i   = douta_i_q;
    assign bus.doutb_r   = doutb_r_q;
    assign bus.doutb_i   = doutb_i_q;

endmodule
